// File: rtl/jtag_tap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
//   Shared types and constants for the JTAG TAP controller slice.
//   - tap_ctrl_fsm_t : the 16 IEEE 1149.1 TAP states. The encoding follows
//                      the traditional 1149.1 reference values.
//   - IR_WIDTH_DEF, IDCODE/BYPASS opcode and IDCODE value defaults
//   - jtag_user_opc_t: user instructions that select the JTAG-to-AXI bridge
//                      data registers
//   - tap_next_state(): the 1149.1 next-state function
// ---------------------------------------------------------------------------
package jtag_pkg;

    localparam int          IR_WIDTH_DEF    = 4;
    localparam logic [3:0]  IDCODE_OPC_DEF  = 4'b0001;
    localparam logic [3:0]  BYPASS_OPC_DEF  = 4'b1111;
    localparam logic [31:0] IDCODE_VAL_DEF  = 32'h1000_0001;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_ctrl_fsm_t;

    // Opcodes decoded downstream by the JTAG-to-AXI bridge data registers.
    typedef enum logic [3:0] {
        USER_AXI_ADDR   = 4'b0100,
        USER_AXI_WDATA  = 4'b0101,
        USER_AXI_RDATA  = 4'b0110,
        USER_AXI_STATUS = 4'b0111
    } jtag_user_opc_t;

    function automatic tap_ctrl_fsm_t tap_next_state(input tap_ctrl_fsm_t cur,
                                                     input logic          tms);
        tap_ctrl_fsm_t nxt;
        nxt = TEST_LOGIC_RESET;
        case (cur)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// ---------------------------------------------------------------------------
// jtag_tap_ctrl_if
//   Serial and strobe signals between a TAP controller and whatever drives
//   it (probe, pad wrapper or bench) plus the downstream user DR.
//   slave  modport : the TAP controller side
//   master modport : the driving side
//   Signals: tms, tdi, user_tdo_i (to TAP); tdo, tdo_oe, tap_state_o, ir_o,
//            capture_dr_o, shift_dr_o, update_dr_o (from TAP)
// ---------------------------------------------------------------------------
interface jtag_tap_ctrl_if
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = IR_WIDTH_DEF
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_oe;
    tap_ctrl_fsm_t       tap_state_o;
    logic [IR_WIDTH-1:0] ir_o;
    logic                capture_dr_o;
    logic                shift_dr_o;
    logic                update_dr_o;
    logic                user_tdo_i;

    modport slave (
        input  tms, tdi, user_tdo_i,
        output tdo, tdo_oe, tap_state_o, ir_o,
               capture_dr_o, shift_dr_o, update_dr_o
    );

    modport master (
        output tms, tdi, user_tdo_i,
        input  tdo, tdo_oe, tap_state_o, ir_o,
               capture_dr_o, shift_dr_o, update_dr_o
    );
endinterface

// File: rtl/jtag_tap_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
//   1149.1 TAP state register. Advances on every rising tck edge using tms;
//   trst (synchronous, active-high) forces TEST_LOGIC_RESET.
//   Ports: tck, trst, tms (in); state (out, registered tap_ctrl_fsm_t)
// ---------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic          tck,
    input  logic          trst,
    input  logic          tms,
    output tap_ctrl_fsm_t state
);

    // The state itself is the registered output; all decode lives in the
    // parent so strobes carry no extra latency.
    always_ff @(posedge tck) begin
        if (trst) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            state <= tap_next_state(state, tms);
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_tap_ctrl
//   IEEE 1149.1 TAP controller for the debug port. Holds the instruction
//   register, the BYPASS bit, the optional IDCODE register and the tdo mux,
//   and decodes capture/shift/update strobes for user data registers.
//
//   Ports:
//     tck   - sole clock, all state on the rising edge
//     trst  - synchronous active-high reset
//     bus   - jtag_tap_ctrl_if.slave (tms, tdi, tdo, tdo_oe, tap_state_o,
//             ir_o, capture/shift/update_dr_o, user_tdo_i)
//
//   Configuration macro JTAG_TAP_IDCODE_EN:
//     defined   - 32-bit IDCODE register present, reset instruction IDCODE
//     undefined - no IDCODE register, reset instruction BYPASS, and the
//                 IDCODE opcode simply selects bypass
// ---------------------------------------------------------------------------
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH   = IR_WIDTH_DEF,
    parameter logic [31:0]         IDCODE_VAL = IDCODE_VAL_DEF,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPC = IR_WIDTH'(IDCODE_OPC_DEF),
    parameter logic [IR_WIDTH-1:0] BYPASS_OPC = {IR_WIDTH{1'b1}}
)(
    input  logic           tck,
    input  logic           trst,
    jtag_tap_ctrl_if.slave bus
);

    // 1149.1 mandates a 1 in the IDCODE LSB so it is distinguishable from
    // a bypass register on the chain.
    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
        $error("IDCODE_VAL bit 0 must be 1");
    end
    if (IR_WIDTH < 2) begin : g_ir_width_check
        $error("IR_WIDTH must be at least 2");
    end

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_OPC = IDCODE_OPC;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OPC = BYPASS_OPC;
`endif

    tap_ctrl_fsm_t       state;
    logic [IR_WIDTH-1:0] ir_reg;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_bit;
    logic                sel_bypass;
    logic                sel_idcode;
    logic                sel_user;
    logic                idcode_lsb;
    logic                tdo_c;
    logic                tdo_oe_c;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (bus.tms),
        .state (state)
    );

    // DR selection. All-zeros is treated as bypass so a stuck-at-0 chain
    // never reaches a user register by accident.
`ifdef JTAG_TAP_IDCODE_EN
    assign sel_bypass = (ir_reg == BYPASS_OPC) || (ir_reg == '0);
    assign sel_idcode = !sel_bypass && (ir_reg == IDCODE_OPC);
`else
    assign sel_bypass = (ir_reg == BYPASS_OPC) || (ir_reg == '0)
                     || (ir_reg == IDCODE_OPC);
    assign sel_idcode = 1'b0;
`endif
    assign sel_user = !sel_bypass && !sel_idcode;

    // Instruction register path. Entering TLR by any route reloads the
    // reset instruction on the following edge; PAUSE_IR falls to default
    // and holds ir_shift.
    always_ff @(posedge tck) begin
        if (trst) begin
            ir_reg   <= RESET_OPC;
            ir_shift <= '0;
        end else begin
            case (state)
                TEST_LOGIC_RESET: ir_reg   <= RESET_OPC;
                CAPTURE_IR:       ir_shift <= IR_WIDTH'(2'b01);
                SHIFT_IR:         ir_shift <= {bus.tdi, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_reg   <= ir_shift;
                default:          ;
            endcase
        end
    end

    // Bypass bit: captures 0, shifts tdi while selected.
    always_ff @(posedge tck) begin
        if (trst) begin
            bypass_bit <= 1'b0;
        end else if (sel_bypass) begin
            if (state == CAPTURE_DR) begin
                bypass_bit <= 1'b0;
            end else if (state == SHIFT_DR) begin
                bypass_bit <= bus.tdi;
            end
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_shift;

    // IDCODE register: captures the device ID, shifts LSB-first with tdi
    // entering at bit 31.
    always_ff @(posedge tck) begin
        if (trst) begin
            idcode_shift <= IDCODE_VAL;
        end else if (sel_idcode) begin
            if (state == CAPTURE_DR) begin
                idcode_shift <= IDCODE_VAL;
            end else if (state == SHIFT_DR) begin
                idcode_shift <= {bus.tdi, idcode_shift[31:1]};
            end
        end
    end

    assign idcode_lsb = idcode_shift[0];
`else
    assign idcode_lsb = 1'b0;
`endif

    // tdo mux straight from registered state; retiming onto the falling
    // edge is left to the pad wrapper.
    always_comb begin
        tdo_c    = 1'b0;
        tdo_oe_c = 1'b0;
        case (state)
            SHIFT_IR: begin
                tdo_c    = ir_shift[0];
                tdo_oe_c = 1'b1;
            end
            SHIFT_DR: begin
                tdo_oe_c = 1'b1;
                if (sel_user) begin
                    tdo_c = bus.user_tdo_i;
                end else if (sel_idcode) begin
                    tdo_c = idcode_lsb;
                end else begin
                    tdo_c = bypass_bit;
                end
            end
            default: ;
        endcase
    end

    assign bus.tdo          = tdo_c;
    assign bus.tdo_oe       = tdo_oe_c;
    assign bus.tap_state_o  = state;
    assign bus.ir_o         = ir_reg;
    assign bus.capture_dr_o = (state == CAPTURE_DR) && sel_user;
    assign bus.shift_dr_o   = (state == SHIFT_DR)   && sel_user;
    assign bus.update_dr_o  = (state == UPDATE_DR)  && sel_user;

endmodule
